// File: rtl/int_mult_arb_pkg.sv
// Shared constants and the return-tag type for the two-client integer multiplier arbiter.
package int_mult_arb_pkg;
  localparam int NUM_LANES = 4;
  localparam int OP_W      = 54;
  localparam int RES_W     = 108;

  typedef struct packed {
    logic valid;
    logic client_id;
  } client_tag_t;
endpackage

// File: rtl/int_mult_arbiter_tag_delay_line.sv
// Fixed-depth shift register carrying {valid, client_id} alongside the multiplier pipeline.
import int_mult_arb_pkg::*;

module tag_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  client_tag_t tag_in,
  output client_tag_t tag_out
);
  client_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];
endmodule

// File: rtl/int_mult_arbiter.sv
// Round-robin arbiter sharing one 4-lane integer multiplier bank between two clients,
// with a tag pipeline that steers each returning product's valid strobe to its owner.
import int_mult_arb_pkg::*;

module int_mult_arbiter #(
  parameter int MULT_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [OP_W-1:0]  c0_mult_a [0:NUM_LANES-1],
  input  logic [OP_W-1:0]  c0_mult_b [0:NUM_LANES-1],
  input  logic [OP_W-1:0]  c1_mult_a [0:NUM_LANES-1],
  input  logic [OP_W-1:0]  c1_mult_b [0:NUM_LANES-1],
  output logic [1:0]       gnt,
  output logic [RES_W-1:0] c0_result [0:NUM_LANES-1],
  output logic [RES_W-1:0] c1_result [0:NUM_LANES-1],
  output logic             c0_result_valid,
  output logic             c1_result_valid,
  output logic [OP_W-1:0]  mult_a [0:NUM_LANES-1],
  output logic [OP_W-1:0]  mult_b [0:NUM_LANES-1],
  input  logic [RES_W-1:0] int_mult_result [0:NUM_LANES-1],
  output logic             busy
);
  localparam int CNT_W = $clog2(MULT_LATENCY + 2);

  // Handshake: a client raises req[i] with its operands and holds both until it
  // sees gnt[i] in the same cycle; the transfer happens on that cycle's rising edge.
  logic             last_c1;
  logic             grant;
  logic             gnt_id;
  logic             ret;
  logic [CNT_W-1:0] in_flight;
  client_tag_t      tag_in;
  client_tag_t      tag_out;

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_c1 ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign grant  = |gnt;
  assign gnt_id = gnt[1];

  // Reset to "client 1 last" so client 0 wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_c1 <= 1'b1;
    else if (grant) last_c1 <= gnt_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        mult_a[i] <= '0;
        mult_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        mult_a[i] <= !grant ? '0 : (gnt_id ? c1_mult_a[i] : c0_mult_a[i]);
        mult_b[i] <= !grant ? '0 : (gnt_id ? c1_mult_b[i] : c0_mult_b[i]);
      end
    end
  end

  assign tag_in.valid     = grant;
  assign tag_in.client_id = gnt_id;

  tag_delay_line #(
    .DEPTH (1 + MULT_LATENCY)
  ) u_tag_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign ret             = tag_out.valid;
  assign c0_result_valid = ret && !tag_out.client_id;
  assign c1_result_valid = ret &&  tag_out.client_id;
  assign c0_result       = int_mult_result;
  assign c1_result       = int_mult_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      unique case ({grant, ret})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign busy = (in_flight != '0);
endmodule

// File: tb/tb_int_mult_arbiter.sv
// Directed-plus-random bench for int_mult_arbiter against a queue-based model of grants and returns.
module tb_int_mult_arbiter;
  localparam int L   = 4;
  localparam int NL  = 4;
  localparam int OPW = 54;
  localparam int RW  = 108;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req;
  logic [OPW-1:0]  c0_a [0:NL-1];
  logic [OPW-1:0]  c0_b [0:NL-1];
  logic [OPW-1:0]  c1_a [0:NL-1];
  logic [OPW-1:0]  c1_b [0:NL-1];
  logic [1:0]      gnt;
  logic [RW-1:0]   c0_result [0:NL-1];
  logic [RW-1:0]   c1_result [0:NL-1];
  logic            c0_result_valid, c1_result_valid;
  logic [OPW-1:0]  mult_a [0:NL-1];
  logic [OPW-1:0]  mult_b [0:NL-1];
  logic [RW-1:0]   int_mult_result [0:NL-1];
  logic            busy;

  int_mult_arbiter #(.MULT_LATENCY(L)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .c0_mult_a       (c0_a),
    .c0_mult_b       (c0_b),
    .c1_mult_a       (c1_a),
    .c1_mult_b       (c1_b),
    .gnt             (gnt),
    .c0_result       (c0_result),
    .c1_result       (c1_result),
    .c0_result_valid (c0_result_valid),
    .c1_result_valid (c1_result_valid),
    .mult_a          (mult_a),
    .mult_b          (mult_b),
    .int_mult_result (int_mult_result),
    .busy            (busy)
  );

  // Clock: inputs change on the falling edge, DUT state moves on the rising edge.
  always #5 clk = ~clk;

  // Behavioural multiplier bank: product of the registered operands, L cycles later.
  logic [RW-1:0] bank [0:L-1][0:NL-1];
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) bank[0][l] <= RW'(mult_a[l]) * RW'(mult_b[l]);
    for (int s = 1; s < L; s++) bank[s] <= bank[s-1];
  end
  always_comb begin
    for (int l = 0; l < NL; l++) int_mult_result[l] = bank[L-1][l];
  end

  // Reference model: pending returns in grant order, round-robin memory, next operands.
  typedef struct {
    int          due;
    bit          cl;
    logic [RW-1:0] p [0:NL-1];
  } ret_t;
  ret_t           exp_q [$];
  bit             last_cl;
  logic [OPW-1:0] exp_a [0:NL-1];
  logic [OPW-1:0] exp_b [0:NL-1];
  bit [1:0]       pend;
  int             cyc;
  int             checks;
  int             errors;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic rand_ops(input bit cl);
    for (int l = 0; l < NL; l++) begin
      if (cl) begin
        c1_a[l] = OPW'({$urandom(), $urandom()});
        c1_b[l] = OPW'({$urandom(), $urandom()});
      end else begin
        c0_a[l] = OPW'({$urandom(), $urandom()});
        c0_b[l] = OPW'({$urandom(), $urandom()});
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_cl = 1'b1;
    pend    = 2'b00;
    for (int l = 0; l < NL; l++) begin
      exp_a[l] = '0;
      exp_b[l] = '0;
    end
  endtask

  task automatic check_regs();
    for (int l = 0; l < NL; l++) begin
      chk("mult_a", 128'(mult_a[l]), 128'(exp_a[l]));
      chk("mult_b", 128'(mult_b[l]), 128'(exp_b[l]));
    end
  endtask

  // One clock cycle: drive req, check everything visible this cycle, advance the model.
  task automatic step(input logic [1:0] r);
    logic [1:0] eg;
    bit         due_now;
    bit         cl;
    req = r;
    #1;
    case (r)
      2'b01:   eg = 2'b01;
      2'b10:   eg = 2'b10;
      2'b11:   eg = last_cl ? 2'b01 : 2'b10;
      default: eg = 2'b00;
    endcase
    chk("gnt", 128'(gnt), 128'(eg));
    check_regs();
    due_now = (exp_q.size() != 0) && (exp_q[0].due == cyc);
    chk("c0_valid", 128'(c0_result_valid), 128'(due_now && !exp_q[0].cl));
    chk("c1_valid", 128'(c1_result_valid), 128'(due_now &&  exp_q[0].cl));
    if (due_now) begin
      for (int l = 0; l < NL; l++) begin
        chk("c0_result", 128'(c0_result[l]), 128'(exp_q[0].p[l]));
        chk("c1_result", 128'(c1_result[l]), 128'(exp_q[0].p[l]));
      end
    end
    chk("busy", 128'(busy), 128'(exp_q.size() != 0));
    chk("in_flight", 128'(dut.in_flight), 128'(exp_q.size()));
    if (due_now) void'(exp_q.pop_front());
    if (eg != 2'b00) begin
      ret_t e;
      cl    = eg[1];
      e.due = cyc + 1 + L;
      e.cl  = cl;
      for (int l = 0; l < NL; l++) begin
        exp_a[l] = cl ? c1_a[l] : c0_a[l];
        exp_b[l] = cl ? c1_b[l] : c0_b[l];
        e.p[l]   = RW'(exp_a[l]) * RW'(exp_b[l]);
      end
      exp_q.push_back(e);
      last_cl = cl;
    end else begin
      for (int l = 0; l < NL; l++) begin
        exp_a[l] = '0;
        exp_b[l] = '0;
      end
    end
    pend = r & ~eg;
    cyc++;
    @(negedge clk);
    if (!pend[0]) rand_ops(1'b0);
    if (!pend[1]) rand_ops(1'b1);
  endtask

  // One cycle with rst_n low; outputs must be cleared while requests are still presented.
  task automatic do_reset(input logic [1:0] r);
    rst_n = 1'b0;
    req   = r;
    model_reset();
    #1;
    chk("rst_gnt", 128'(gnt), 128'(0));
    check_regs();
    chk("rst_c0_valid", 128'(c0_result_valid), 128'(0));
    chk("rst_c1_valid", 128'(c1_result_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_flight", 128'(dut.in_flight), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    req    = 2'b00;
    rand_ops(1'b0);
    rand_ops(1'b1);
    do_reset(2'b11);

    // Contention straight out of reset: 01,10,01,10, returns alternate.
    for (int i = 0; i < 4; i++) step(2'b11);
    for (int i = 0; i < 6; i++) step(2'b00);

    // Idle leaves the pointer alone: client 1 won last, so client 0 wins now.
    step(2'b11);
    for (int i = 0; i < 6; i++) step(2'b00);

    // Single client 0 with 3 x 5 on lane 0.
    c0_a[0] = OPW'(3);
    c0_b[0] = OPW'(5);
    step(2'b01);
    for (int i = 0; i < 7; i++) step(2'b00);

    // Eight back-to-back client 1 grants; in-flight peaks at 1+L.
    for (int i = 0; i < 8; i++) step(2'b10);
    for (int i = 0; i < 7; i++) step(2'b00);

    // Random traffic; a client keeps its request up until it is granted.
    for (int i = 0; i < 80; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3)) | pend;
      step(r);
    end
    for (int i = 0; i < 7; i++) step(2'b00);

    // Reset mid-operation flushes in-flight work.
    step(2'b01);
    step(2'b10);
    do_reset(2'b11);
    for (int i = 0; i < 8; i++) step(2'b00);

    // Pointer restored by reset: client 0 wins contention again.
    step(2'b11);
    step(2'b11);
    for (int i = 0; i < 7; i++) step(2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
